// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Inhibits the bus, issues a request-to-send, and shifts one command byte
// (LSB first, odd parity, stop) on device clock falls. It then samples the
// device acknowledge and waits for the bus to go idle. If the device stops
// clocking, the frame is aborted with a timeout status. Pin outputs are
// open-drain enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int SETUP_CYCLES   = 200,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic [1:0] status,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       clk_oe,
  output logic       data_oe
);

  localparam int MAX_IS = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int MAX_P  = (MAX_IS > TIMEOUT_CYCLES) ? MAX_IS : TIMEOUT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  localparam logic [1:0] STATUS_ACK     = 2'b00;
  localparam logic [1:0] STATUS_NOACK   = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // PS/2 parity bit makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       bit_cnt_r;
  logic [9:0]       frame_r;
  logic [1:0]       status_nx_r;

  logic clk_meta_r, clk_sync_r, clk_prev_r;
  logic data_meta_r, data_sync_r;
  logic fall_s;
  logic timeout_s;

  // Two-flop synchronisers for both pins plus a history flop on the clock pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk_in;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data_in;
      data_sync_r <= data_meta_r;
    end
  end

  // Device clock falling edge, and a timeout that only fires when no fall is seen.
  always_comb begin
    fall_s    = clk_prev_r & ~clk_sync_r;
    timeout_s = 1'b0;
    if ((state_r == ST_SHIFT) || (state_r == ST_ACK) || (state_r == ST_WAIT_IDLE)) begin
      timeout_s = ~fall_s & (cnt_r == TIMEOUT_LAST);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Frame sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      bit_cnt_r   <= 4'd0;
      frame_r     <= 10'd0;
      status_nx_r <= STATUS_ACK;
      status      <= STATUS_ACK;
      clk_oe      <= 1'b0;
      data_oe     <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      rx_inhibit  <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (timeout_s) begin
        state_r    <= ST_IDLE;
        clk_oe     <= 1'b0;
        data_oe    <= 1'b0;
        status     <= STATUS_TIMEOUT;
        done       <= 1'b1;
        tx_ready   <= 1'b1;
        busy       <= 1'b0;
        rx_inhibit <= 1'b0;
        cnt_r      <= CNT_ZERO;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (tx_valid && tx_ready) begin
              frame_r    <= {1'b1, odd_parity(tx_data), tx_data};
              state_r    <= ST_INHIBIT;
              clk_oe     <= 1'b1;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              rx_inhibit <= 1'b1;
              cnt_r      <= CNT_ZERO;
              bit_cnt_r  <= 4'd0;
            end
          end
          ST_INHIBIT: begin
            if (cnt_r == INHIBIT_LAST) begin
              cnt_r   <= CNT_ZERO;
              data_oe <= 1'b1;
              state_r <= ST_REQ;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          ST_REQ: begin
            if (cnt_r == SETUP_LAST) begin
              cnt_r   <= CNT_ZERO;
              clk_oe  <= 1'b0;
              state_r <= ST_SHIFT;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          ST_SHIFT: begin
            if (fall_s) begin
              cnt_r     <= CNT_ZERO;
              data_oe   <= ~frame_r[bit_cnt_r];
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd9) begin
                state_r <= ST_ACK;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          ST_ACK: begin
            if (fall_s) begin
              cnt_r       <= CNT_ZERO;
              status_nx_r <= data_sync_r ? STATUS_NOACK : STATUS_ACK;
              state_r     <= ST_WAIT_IDLE;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          ST_WAIT_IDLE: begin
            if (clk_sync_r && data_sync_r) begin
              state_r    <= ST_IDLE;
              done       <= 1'b1;
              status     <= status_nx_r;
              tx_ready   <= 1'b1;
              busy       <= 1'b0;
              rx_inhibit <= 1'b0;
              cnt_r      <= CNT_ZERO;
            end else if (fall_s) begin
              cnt_r <= CNT_ZERO;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            clk_oe     <= 1'b0;
            data_oe    <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            rx_inhibit <= 1'b0;
            cnt_r      <= CNT_ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a cycle-based PS/2 device model.
// Expected frame bits, parity and status come from a small reference model.
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, rx_inhibit, done;
  logic [1:0] status;
  logic       clk_oe, data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int frame_base = 0;

  // Open-drain bus: host enables and device drivers wired-AND on the pins.
  assign ps2_clk_in  = ~clk_oe & dev_clk;
  assign ps2_data_in = ~data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .SETUP_CYCLES(4),
    .TIMEOUT_CYCLES(500)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .busy(busy),
    .rx_inhibit(rx_inhibit),
    .done(done),
    .status(status),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_oe(clk_oe),
    .data_oe(data_oe)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  // Count done pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // Hard stop if the run wanders off.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference frame: data LSB first, then odd parity, then stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    int ones;
    logic par;
    ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(b[k]);
    par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  // One host transfer. n_clocks = 11 for a full frame with ack slot,
  // fewer to model a device that stops clocking.
  task automatic run_frame(input logic [7:0] b, input int n_clocks, input bit ack, input bit inject);
    int hi;
    int first_d;
    int w;
    logic [9:0] exp_bits;
    logic [9:0] got_bits;
    bit drove;
    exp_bits = ref_frame(b);
    got_bits = 10'd0;
    frame_base = done_cnt;
    tx_data = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    check_eq("busy_on_accept", 32'(busy), 32'd1);
    check_eq("rx_inhibit_on_accept", 32'(rx_inhibit), 32'd1);
    check_eq("tx_ready_on_accept", 32'(tx_ready), 32'd0);
    hi = 0;
    first_d = 0;
    while (clk_oe === 1'b1 && hi < 200) begin
      hi++;
      if (data_oe === 1'b1 && first_d == 0) first_d = hi;
      tick(1);
    end
    check_eq("clk_oe_low_cycles", 32'(hi), 32'd24);
    check_eq("data_oe_first_cycle", 32'(first_d), 32'd21);
    check_eq("start_bit_held", 32'(data_oe), 32'd1);
    tick(30);
    for (int i = 0; i < n_clocks && i < 10; i++) begin
      dev_clk = 1'b0;
      if (inject && i == 2) begin
        tx_data = 8'h00;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(19);
      end else begin
        tick(20);
      end
      dev_clk = 1'b1;
      got_bits[i] = ps2_data_in;
      tick(20);
    end
    for (int i = 0; i < n_clocks && i < 10; i++) begin
      check_eq($sformatf("bit%0d_of_%02h", i, b), 32'(got_bits[i]), 32'(exp_bits[i]));
    end
    if (n_clocks >= 11) begin
      drove = 1'b0;
      if (ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (20) begin
        drove |= clk_oe | data_oe;
        tick(1);
      end
      dev_clk = 1'b1;
      repeat (20) begin
        drove |= clk_oe | data_oe;
        tick(1);
      end
      dev_data = 1'b1;
      w = 0;
      while (done_cnt == frame_base && w < 200) begin
        tick(1);
        w++;
      end
      tick(5);
      check_eq("done_pulses", 32'(done_cnt - frame_base), 32'd1);
      check_eq("status", 32'(status), ack ? 32'd0 : 32'd1);
      check_eq("tx_ready_after", 32'(tx_ready), 32'd1);
      check_eq("busy_after", 32'(busy), 32'd0);
      check_eq("rx_inhibit_after", 32'(rx_inhibit), 32'd0);
      check_eq("no_drive_after_stop", 32'(drove), 32'd0);
      check_eq("clk_oe_idle", 32'(clk_oe), 32'd0);
      check_eq("data_oe_idle", 32'(data_oe), 32'd0);
    end
  endtask

  initial begin
    int elapsed;
    int w;
    logic [7:0] rb;

    // Reset state.
    tick(3);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_status", 32'(status), 32'd0);
    check_eq("rst_clk_oe", 32'(clk_oe), 32'd0);
    check_eq("rst_data_oe", 32'(data_oe), 32'd0);
    rst = 1'b1;
    tick(3);

    // Fixed commands and random bytes, device acknowledges.
    run_frame(8'hED, 11, 1'b1, 1'b0);
    run_frame(8'hF4, 11, 1'b1, 1'b0);
    run_frame(8'hFF, 11, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      rb = 8'($urandom_range(0, 255));
      run_frame(rb, 11, 1'b1, 1'b0);
    end

    // Request during SHIFT must be ignored.
    run_frame(8'hA5, 11, 1'b1, 1'b1);
    tick(40);
    check_eq("inject_no_extra_done", 32'(done_cnt - frame_base), 32'd1);
    check_eq("inject_idle", 32'(busy), 32'd0);

    // Device stops after 4 falls: timeout roughly 500 cycles after the last fall.
    rb = 8'($urandom_range(0, 255));
    run_frame(rb, 4, 1'b1, 1'b0);
    elapsed = 40;
    w = 0;
    while (done_cnt == frame_base && w < 800) begin
      tick(1);
      w++;
    end
    elapsed += w;
    check_eq("timeout_window", 32'((elapsed >= 495 && elapsed <= 512) ? 1 : 0), 32'd1);
    check_eq("timeout_status", 32'(status), 32'd2);
    check_eq("timeout_clk_oe", 32'(clk_oe), 32'd0);
    check_eq("timeout_data_oe", 32'(data_oe), 32'd0);
    check_eq("timeout_tx_ready", 32'(tx_ready), 32'd1);
    tick(5);
    check_eq("timeout_done_pulses", 32'(done_cnt - frame_base), 32'd1);

    // Next request after timeout is accepted normally.
    rb = 8'($urandom_range(0, 255));
    run_frame(rb, 11, 1'b1, 1'b0);

    // Missing acknowledge.
    rb = 8'($urandom_range(0, 255));
    run_frame(rb, 11, 1'b0, 1'b0);

    // Reset in the middle of SHIFT (D2 of 0x3A is 0, so data is being pulled low).
    run_frame(8'h3A, 3, 1'b1, 1'b0);
    check_eq("pre_reset_busy", 32'(busy), 32'd1);
    check_eq("pre_reset_data_oe", 32'(data_oe), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_clk_oe", 32'(clk_oe), 32'd0);
    check_eq("mid_rst_data_oe", 32'(data_oe), 32'd0);
    check_eq("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    tick(2);
    rst = 1'b1;
    tick(50);
    check_eq("post_rst_tx_ready", 32'(tx_ready), 32'd1);
    check_eq("post_rst_status", 32'(status), 32'd0);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    check_eq("post_rst_no_done", 32'(done_cnt - frame_base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
